// File: rtl/keypad_entry_sequencer.sv
// Keypad front end for comb_lock: debounced strobe capture, 4-digit BCD buffer, ENTER replay.
// Optional ENTRY_TIMEOUT_EN clears a stale partial entry after TIMEOUT_CYCLES of inactivity.
module keypad_entry_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000,
  parameter logic [3:0]  CLEAR_CODE      = 4'hA,
  parameter logic [3:0]  ENTER_CODE      = 4'hB
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_strobe,
  input  logic [3:0] key_code,
  input  logic       lock_in,
  output logic       enter_button,
  output logic [3:0] ip_pass,
  output logic [2:0] digit_count,
  output logic       entry_err,
  output logic       busy
);

  localparam int unsigned   HW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] COLLECT = 3'd0;
  localparam logic [2:0] SEND_EN = 3'd1;
  localparam logic [2:0] SEND_D1 = 3'd2;
  localparam logic [2:0] SEND_D2 = 3'd3;
  localparam logic [2:0] SEND_D3 = 3'd4;
  localparam logic [2:0] SEND_D4 = 3'd5;

  logic          s1_q, s2_q, s3_q;
  logic [HW-1:0] hold_q, hold_d;
  logic [2:0]    state_q, state_d;
  logic [2:0]    count_q, count_d;
  logic [3:0]    slot_q [4];
  logic [3:0]    slot_d [4];
  logic          enter_q, enter_d, busy_q, busy_d, err_q, err_d;
  logic [3:0]    pass_q, pass_d;
  logic          press_ev, is_digit;
`ifdef ENTRY_TIMEOUT_EN
  logic [31:0]   idle_q, idle_d;
`endif

  assign press_ev = s2_q & ~s3_q & (hold_q == '0);
  assign is_digit = (key_code <= 4'd9);

  always_comb begin
    hold_d  = hold_q;
    state_d = state_q;
    count_d = count_q;
    slot_d  = slot_q;
    err_d   = 1'b0;
    if (press_ev)
      hold_d = HOLD_LOAD;
    else if (hold_q != '0)
      hold_d = hold_q - 1'b1;

    case (state_q)
      COLLECT: begin
        // lock_in has priority over any event arriving in the same cycle
        if (lock_in) begin
          count_d = '0;
        end else if (press_ev) begin
          if (is_digit) begin
            if (count_q < 3'd4) begin
              slot_d[count_q[1:0]] = key_code;
              count_d              = count_q + 3'd1;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_code == CLEAR_CODE) begin
            count_d = '0;
          end else if (key_code == ENTER_CODE) begin
            if (count_q == 3'd4) begin
              state_d = SEND_EN;
            end else begin
              count_d = '0;
              err_d   = 1'b1;
            end
          end
        end
      end
      SEND_EN: state_d = SEND_D1;
      SEND_D1: state_d = SEND_D2;
      SEND_D2: state_d = SEND_D3;
      SEND_D3: state_d = SEND_D4;
      SEND_D4: begin
        state_d = COLLECT;
        count_d = '0;
      end
      default: state_d = COLLECT;
    endcase

`ifdef ENTRY_TIMEOUT_EN
    idle_d = '0;
    if (state_q == COLLECT && !lock_in && !press_ev && count_q != '0) begin
      if (idle_q >= 32'(TIMEOUT_CYCLES - 1)) begin
        count_d = '0;
        err_d   = 1'b1;
      end else begin
        idle_d = idle_q + 32'd1;
      end
    end
`endif

    // Outputs are decoded from the next state so they align with the state register.
    enter_d = (state_d == SEND_EN);
    busy_d  = (state_d != COLLECT);
    case (state_d)
      SEND_D1: pass_d = slot_q[0];
      SEND_D2: pass_d = slot_q[1];
      SEND_D3: pass_d = slot_q[2];
      SEND_D4: pass_d = slot_q[3];
      default: pass_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      hold_q  <= '0;
      state_q <= COLLECT;
      count_q <= '0;
      for (int unsigned i = 0; i < 4; i++) slot_q[i] <= '0;
      enter_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      pass_q  <= '0;
    end else begin
      s1_q    <= key_strobe;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      hold_q  <= hold_d;
      state_q <= state_d;
      count_q <= count_d;
      slot_q  <= slot_d;
      enter_q <= enter_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`endif

  assign enter_button = enter_q;
  assign ip_pass      = pass_q;
  assign digit_count  = count_q;
  assign entry_err    = err_q;
  assign busy         = busy_q;

endmodule
